// File: rtl/key_debounce_pkg.sv
// Shared definitions for the four-channel key debouncer:
// channel FSM encoding and 50 MHz default timing.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_e;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int unsigned DEF_LONG_CYCLES     = 50_000_000;
    localparam int unsigned DEF_REPEAT_CYCLES   = 10_000_000;

    // Bits needed to count 0 .. n-1.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchronizer, debounce FSM,
// long-press and auto-repeat counters.
module key_debounce_ch
    import key_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic level,
    output logic press,
    output logic rel,
    output logic long_hit,
    output logic rpt
);

    localparam int unsigned DW = cnt_w(DEBOUNCE_CYCLES);
    localparam int unsigned LW = cnt_w(LONG_CYCLES);
    localparam int unsigned RW = cnt_w(REPEAT_CYCLES);

    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] L_LAST = LW'(LONG_CYCLES - 1);
    localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYCLES - 1);

    logic            sync_a;
    logic            sync_b;
    logic            hit;
    key_state_e      state;
    key_state_e      state_d;
    logic [DW-1:0]   cnt;
    logic [DW-1:0]   cnt_d;
    logic [LW-1:0]   hold;
    logic [LW-1:0]   hold_d;
    logic [RW-1:0]   rcnt;
    logic [RW-1:0]   rcnt_d;
    logic            long_done;
    logic            long_done_d;
    logic            level_d;
    logic            press_d;
    logic            rel_d;
    logic            long_d;
    logic            rpt_d;
    logic            holding;

    assign hit = ~sync_b;

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        hold_d      = hold;
        rcnt_d      = rcnt;
        long_done_d = long_done;
        level_d     = level;
        press_d     = 1'b0;
        rel_d       = 1'b0;
        long_d      = 1'b0;
        rpt_d       = 1'b0;

        unique case (state)
            IDLE: begin
                if (hit) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!hit) begin
                    state_d = IDLE;
                end else if (cnt == D_LAST) begin
                    state_d     = HELD;
                    level_d     = 1'b1;
                    press_d     = 1'b1;
                    cnt_d       = '0;
                    hold_d      = '0;
                    rcnt_d      = '0;
                    long_done_d = 1'b0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            HELD: begin
                if (!hit) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (hit) begin
                    state_d = HELD;
                end else if (cnt == D_LAST) begin
                    state_d     = IDLE;
                    level_d     = 1'b0;
                    rel_d       = 1'b1;
                    cnt_d       = '0;
                    hold_d      = '0;
                    rcnt_d      = '0;
                    long_done_d = 1'b0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Hold timing runs through release bounce, stops once release is accepted.
        holding = (state == HELD || state == RELEASE_WAIT)
                  && (state_d != IDLE);

        if (holding) begin
            if (!long_done) begin
                if (hold == L_LAST) begin
                    long_d      = 1'b1;
                    long_done_d = 1'b1;
                    rcnt_d      = '0;
                end else begin
                    hold_d = hold + 1'b1;
                end
            end else if (rcnt == R_LAST) begin
                rpt_d  = 1'b1;
                rcnt_d = '0;
            end else begin
                rcnt_d = rcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_a    <= 1'b1;
            sync_b    <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            hold      <= '0;
            rcnt      <= '0;
            long_done <= 1'b0;
            level     <= 1'b0;
            press     <= 1'b0;
            rel       <= 1'b0;
            long_hit  <= 1'b0;
            rpt       <= 1'b0;
        end else begin
            sync_a    <= key_raw;
            sync_b    <= sync_a;
            state     <= state_d;
            cnt       <= cnt_d;
            hold      <= hold_d;
            rcnt      <= rcnt_d;
            long_done <= long_done_d;
            level     <= level_d;
            press     <= press_d;
            rel       <= rel_d;
            long_hit  <= long_d;
            rpt       <= rpt_d;
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Four independent debounced keys with press/release,
// long-press and auto-repeat pulses.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_in,
    output logic [3:0] key_level,
    output logic [3:0] key_press,
    output logic [3:0] key_release,
    output logic [3:0] key_long,
    output logic [3:0] key_repeat
);

    for (genvar i = 0; i < 4; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .key_raw  (key_in[i]),
            .level    (key_level[i]),
            .press    (key_press[i]),
            .rel      (key_release[i]),
            .long_hit (key_long[i]),
            .rpt      (key_repeat[i])
        );
    end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1_000_000, is the number of consecutive stable clock cycles required to accept a press or release (20 ms at 50 MHz).
REQ-002 Parameter LONG_CYCLES, default 50_000_000, is the number of cycles a key must be held after the accepted press to count as a long press (1 s).
REQ-003 Parameter REPEAT_CYCLES, default 10_000_000, is the auto-repeat period after a long press (200 ms).
REQ-004 Port clk, input, 1 bit: the single system clock (50 MHz).
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-low.
REQ-006 Port key_in, input, 4 bits: raw asynchronous key inputs, active-low (0 = pressed).
REQ-007 Port key_level, output, 4 bits: debounced key state, active-high (1 = pressed).
REQ-008 Port key_press, output, 4 bits: one-cycle pulse on each accepted press.
REQ-009 Port key_release, output, 4 bits: one-cycle pulse on each accepted release.
REQ-010 Port key_long, output, 4 bits: one-cycle pulse when a key has been held for LONG_CYCLES.
REQ-011 Port key_repeat, output, 4 bits: one-cycle pulse every REPEAT_CYCLES after key_long while the key stays held.

Function
REQ-012 Each key_in bit SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-013 The four channels SHALL be fully independent; simultaneous activity on several keys SHALL be handled with no interaction between channels.
REQ-014 Each channel SHALL be a four-state FSM:
 - IDLE: released.
 - PRESS_WAIT: candidate press.
 - HELD: accepted press.
 - RELEASE_WAIT: candidate release.
REQ-015 IDLE -> PRESS_WAIT when the synchronized input is 0; the cycle counter clears on entry.
REQ-016 In PRESS_WAIT, a synchronized 1 SHALL return the FSM to IDLE with no output; after DEBOUNCE_CYCLES consecutive 0 samples the FSM SHALL go to HELD, set key_level and pulse key_press in the same cycle.
REQ-017 Press latency SHALL be exactly 2 + DEBOUNCE_CYCLES cycles from the first low key_in sampled at a clk edge to the key_press pulse, for a clean input.
REQ-018 In HELD, a synchronized 1 SHALL move the FSM to RELEASE_WAIT and clear the counter; key_level stays 1.
REQ-019 In RELEASE_WAIT, a synchronized 0 SHALL return the FSM to HELD; any long-press or repeat count SHALL continue counting, not restart.
REQ-020 In RELEASE_WAIT, after DEBOUNCE_CYCLES consecutive 1 samples the FSM SHALL go to IDLE, clear key_level and pulse key_release in the same cycle.
REQ-021 A hold counter SHALL start at the key_press cycle and run while in HELD or RELEASE_WAIT.
REQ-022 When the hold counter reaches LONG_CYCLES, key_long SHALL pulse exactly once per press.
REQ-023 After key_long, key_repeat SHALL pulse every REPEAT_CYCLES until release is accepted.
REQ-024 Glitches shorter than DEBOUNCE_CYCLES SHALL produce no output pulse and no key_level change.
REQ-025 Counters SHALL be sized from the parameters, have no wrap-around, and saturate or clear at their terminal counts.
REQ-026 All outputs SHALL be registered.
REQ-027 key_press and key_release SHALL never assert in the same cycle on the same channel.

Reset
REQ-028 When rst = 0 at a clk edge, then in the next cycle:
 - all FSMs are IDLE;
 - all counters are 0;
 - synchronizer flops are 1 (released);
 - key_level, key_press, key_release, key_long and key_repeat are all 0.
REQ-029 Reset asserted mid-press SHALL discard the press; no key_release SHALL follow.
REQ-030 A key still held when reset deasserts SHALL be re-debounced from IDLE.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding and the default timing constants for 50 MHz.
REQ-032 One sub-module, key_debounce_ch (single-bit channel: synchronizer, FSM and counters), SHALL be instantiated four times by key_debounce.

Verification
REQ-033 Benches SHALL override the parameters to DEBOUNCE_CYCLES=10, LONG_CYCLES=40, REPEAT_CYCLES=8.
REQ-034 Reset: hold rst=0 for 2 cycles with key_in=4'b0000 -> all outputs 0; after release, key_press[3:0] pulses at cycle 12 after deassertion.
REQ-035 Short glitch: key_in[1]=0 for 5 cycles, then 1 -> no pulses, key_level stays 4'b0000.
REQ-036 Clean press: key_in[1]=0 held -> key_press[1] one pulse exactly 12 cycles after the first low sample, key_level[1]=1.
REQ-037 Release bounce: while held, key_in[1]=1 for 6 cycles, then 0, then 1 stable -> key_release[1] once, 12 cycles after the final rise, and no extra key_press.
REQ-038 Long and repeat: hold key_in[2]=0 for 80 cycles -> key_long[2] at 40 cycles after key_press[2], then key_repeat[2] at +8, +16, +24 ..., stopping at release.
REQ-039 Simultaneous keys: key_in 4'b1111 -> 4'b0000 in one cycle -> all four key_press bits pulse in the same cycle.
